// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage in front of a 4096 x 19-bit instruction memory.
//   Owns the 12-bit PC and drives the memory address combinationally. The
//   memory answers in the same cycle. The fetched word is registered into the
//   IF/ID pipeline register under redirect / stall / flush control.
//   Unconditional jumps (opcode 5'b11101, mode 2'b11) are predecoded here, so
//   they redirect the PC without a bubble.
//
//   Optional feature: define FETCH_PERF_CNT_EN to build the saturating 16-bit
//   performance counters. Without it, the perf_* ports are tied to zero.
//
// Parameters
//   RESET_PC   : PC value loaded on reset
//   EARLY_JUMP : 1 = predecode jumps in fetch, 0 = jumps fall through
//
// Ports
//   clk, rst          : rising-edge clock, async active-high reset
//   stall, flush      : hold pipeline / invalidate IF/ID
//   redirect_valid/pc : load PC from a downstream-resolved target
//   imem_addr         : instruction memory address (= pc)
//   imem_instr        : instruction returned for imem_addr
//   ifid_valid/instr/pc1/jumped : IF/ID pipeline register outputs
//   perf_fetch/stall/squash     : performance counters (optional)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [11:0] RESET_PC   = 12'd0,
    parameter bit          EARLY_JUMP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [11:0] redirect_pc,
    output logic [11:0] imem_addr,
    input  logic [18:0] imem_instr,
    output logic        ifid_valid,
    output logic [18:0] ifid_instr,
    output logic [11:0] ifid_pc1,
    output logic        ifid_jumped,
    output logic [15:0] perf_fetch,
    output logic [15:0] perf_stall,
    output logic [15:0] perf_squash
);

    logic [11:0] pc_q, pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [18:0] ifid_instr_q, ifid_instr_d;
    logic [11:0] ifid_pc1_q, ifid_pc1_d;
    logic        ifid_jumped_q, ifid_jumped_d;
    logic        jump_hit_s;
    logic [11:0] pc_inc_s;
    logic [11:0] pc_next_seq_s;

    // Predecode and next-PC selection; pc+1 wraps naturally at 12 bits.
    always_comb begin
        jump_hit_s    = EARLY_JUMP && (imem_instr[18:14] == 5'b11101)
                                   && (imem_instr[13:12] == 2'b11);
        pc_inc_s      = pc_q + 12'd1;
        pc_next_seq_s = jump_hit_s ? imem_instr[11:0] : pc_inc_s;
    end

    // Next-state of PC and IF/ID; redirect beats stall, stall beats flush.
    always_comb begin
        pc_d          = pc_q;
        ifid_valid_d  = ifid_valid_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc1_d    = ifid_pc1_q;
        ifid_jumped_d = ifid_jumped_q;
        if (redirect_valid) begin
            pc_d          = redirect_pc;
            ifid_valid_d  = 1'b0;
            ifid_instr_d  = 19'd0;
            ifid_jumped_d = 1'b0;
        end else if (stall) begin
            // Stalled flush only drops the valid bit; contents stay frozen.
            if (flush) begin
                ifid_valid_d = 1'b0;
            end else begin
                ifid_valid_d = ifid_valid_q;
            end
        end else if (flush) begin
            pc_d         = pc_next_seq_s;
            ifid_valid_d = 1'b0;
            ifid_instr_d = 19'd0;
        end else begin
            pc_d          = pc_next_seq_s;
            ifid_valid_d  = 1'b1;
            ifid_instr_d  = imem_instr;
            ifid_pc1_d    = pc_inc_s;
            ifid_jumped_d = jump_hit_s;
        end
    end

    // PC and IF/ID pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            ifid_valid_q  <= 1'b0;
            ifid_instr_q  <= 19'd0;
            ifid_pc1_q    <= 12'd0;
            ifid_jumped_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            ifid_valid_q  <= ifid_valid_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc1_q    <= ifid_pc1_d;
            ifid_jumped_q <= ifid_jumped_d;
        end
    end

    assign imem_addr   = pc_q;
    assign ifid_valid  = ifid_valid_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_pc1    = ifid_pc1_q;
    assign ifid_jumped = ifid_jumped_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetch_q, perf_fetch_d;
    logic [15:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_squash_q, perf_squash_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic en);
        if (en && (val != 16'hFFFF)) begin
            sat_inc = val + 16'd1;
        end else begin
            sat_inc = val;
        end
    endfunction

    // Counter events: captures, stalled cycles, squashes of a live entry.
    always_comb begin
        perf_fetch_d  = sat_inc(perf_fetch_q, !redirect_valid && !stall && !flush);
        perf_stall_d  = sat_inc(perf_stall_q, stall && !redirect_valid);
        perf_squash_d = sat_inc(perf_squash_q, (redirect_valid || flush) && ifid_valid_q);
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q  <= 16'd0;
            perf_stall_q  <= 16'd0;
            perf_squash_q <= 16'd0;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_stall_q  <= perf_stall_d;
            perf_squash_q <= perf_squash_d;
        end
    end

    assign perf_fetch  = perf_fetch_q;
    assign perf_stall  = perf_stall_q;
    assign perf_squash = perf_squash_q;
`else
    assign perf_fetch  = 16'd0;
    assign perf_stall  = 16'd0;
    assign perf_squash = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. A shared memory returns each address as
//   its own data, except one planted jump word. A second instance built with
//   EARLY_JUMP=0 shows the fall-through behaviour for the same jump.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [11:0] redirect_pc;

    logic [11:0] imem_addr, nj_imem_addr;
    logic [18:0] imem_instr, nj_imem_instr;
    logic        ifid_valid, nj_ifid_valid;
    logic [18:0] ifid_instr, nj_ifid_instr;
    logic [11:0] ifid_pc1, nj_ifid_pc1;
    logic        ifid_jumped, nj_ifid_jumped;
    logic [15:0] perf_fetch, perf_stall, perf_squash;
    logic [15:0] nj_perf_fetch, nj_perf_stall, nj_perf_squash;

    logic [18:0] mem [0:4095];
    logic [18:0] jump_word;

    int n_checks;
    int n_errors;

    assign imem_instr    = mem[imem_addr];
    assign nj_imem_instr = mem[nj_imem_addr];

    fetch_stage #(.RESET_PC(12'd0), .EARLY_JUMP(1'b1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
        .ifid_pc1(ifid_pc1), .ifid_jumped(ifid_jumped),
        .perf_fetch(perf_fetch), .perf_stall(perf_stall), .perf_squash(perf_squash)
    );

    fetch_stage #(.RESET_PC(12'd0), .EARLY_JUMP(1'b0)) dut_nj (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(nj_imem_addr), .imem_instr(nj_imem_instr),
        .ifid_valid(nj_ifid_valid), .ifid_instr(nj_ifid_instr),
        .ifid_pc1(nj_ifid_pc1), .ifid_jumped(nj_ifid_jumped),
        .perf_fetch(nj_perf_fetch), .perf_stall(nj_perf_stall), .perf_squash(nj_perf_squash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [11:0] pc, input logic vld,
                              input logic [18:0] ins, input logic [11:0] pc1, input logic jmp);
        check_eq({tag, ".pc"},     32'(imem_addr),   32'(pc));
        check_eq({tag, ".valid"},  32'(ifid_valid),  32'(vld));
        check_eq({tag, ".instr"},  32'(ifid_instr),  32'(ins));
        check_eq({tag, ".pc1"},    32'(ifid_pc1),    32'(pc1));
        check_eq({tag, ".jumped"}, 32'(ifid_jumped), 32'(jmp));
    endtask

    task automatic check_perf(input string tag, input logic [15:0] f,
                              input logic [15:0] s, input logic [15:0] q);
`ifdef FETCH_PERF_CNT_EN
        check_eq({tag, ".perf_fetch"},  32'(perf_fetch),  32'(f));
        check_eq({tag, ".perf_stall"},  32'(perf_stall),  32'(s));
        check_eq({tag, ".perf_squash"}, 32'(perf_squash), 32'(q));
`else
        check_eq({tag, ".perf_fetch"},  32'(perf_fetch),  32'(f & 16'd0));
        check_eq({tag, ".perf_stall"},  32'(perf_stall),  32'(s & 16'd0));
        check_eq({tag, ".perf_squash"}, 32'(perf_squash), 32'(q & 16'd0));
`endif
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 12'd0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 19'(i);
        end
        jump_word = {5'b11101, 2'b11, 12'd2};
        mem[16]   = jump_word;

        // Reset state
        #12;
        check_ifid("reset", 12'd0, 1'b0, 19'd0, 12'd0, 1'b0);
        check_perf("reset", 16'd0, 16'd0, 16'd0);
        rst = 1'b0;
        check_eq("post_reset.addr", 32'(imem_addr), 32'd0);

        // Free run: addr 0,1,2,3 with IF/ID one cycle behind
        tick(); check_ifid("run1", 12'd1, 1'b1, 19'd0, 12'd1, 1'b0);
        tick(); check_ifid("run2", 12'd2, 1'b1, 19'd1, 12'd2, 1'b0);
        tick(); check_ifid("run3", 12'd3, 1'b1, 19'd2, 12'd3, 1'b0);
        tick(); tick();
        check_ifid("at5", 12'd5, 1'b1, 19'd4, 12'd5, 1'b0);

        // Stall three cycles at pc=5
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_ifid("stall", 12'd5, 1'b1, 19'd4, 12'd5, 1'b0);
        end
        stall = 1'b0;
        tick(); check_ifid("unstall", 12'd6, 1'b1, 19'd5, 12'd6, 1'b0);
        check_perf("after_stall", 16'd6, 16'd3, 16'd0);

        // Redirect to 4, then redirect to 15 together with stall
        redirect_valid = 1'b1; redirect_pc = 12'd4;
        tick(); check_ifid("redir4", 12'd4, 1'b0, 19'd0, 12'd6, 1'b0);
        redirect_pc = 12'd15; stall = 1'b1;
        tick(); check_ifid("redir15_stall", 12'd15, 1'b0, 19'd0, 12'd6, 1'b0);
        redirect_valid = 1'b0; stall = 1'b0;
        tick(); check_ifid("resume16", 12'd16, 1'b1, 19'd15, 12'd16, 1'b0);

        // Early jump at pc=16 to 2; the EARLY_JUMP=0 copy falls through to 17
        tick(); check_ifid("jump", 12'd2, 1'b1, jump_word, 12'd17, 1'b1);
        check_eq("nj.pc",     32'(nj_imem_addr),   32'd17);
        check_eq("nj.jumped", 32'(nj_ifid_jumped), 32'd0);
        check_eq("nj.pc1",    32'(nj_ifid_pc1),    32'd17);
        check_eq("nj.valid",  32'(nj_ifid_valid),  32'd1);

        // Flush without stall: bubble, pc keeps advancing
        flush = 1'b1;
        tick(); check_ifid("flush", 12'd3, 1'b0, 19'd0, 12'd17, 1'b1);
        flush = 1'b0;
        tick(); check_ifid("post_flush", 12'd4, 1'b1, 19'd3, 12'd4, 1'b0);

        // Flush under stall: only valid drops
        flush = 1'b1; stall = 1'b1;
        tick(); check_ifid("stall_flush", 12'd4, 1'b0, 19'd3, 12'd4, 1'b0);
        flush = 1'b0; stall = 1'b0;
        tick(); check_ifid("post_stall_flush", 12'd5, 1'b1, 19'd4, 12'd5, 1'b0);

        // Wrap from 4095 to 0
        redirect_valid = 1'b1; redirect_pc = 12'd4095;
        tick(); check_ifid("redir4095", 12'd4095, 1'b0, 19'd0, 12'd5, 1'b0);
        redirect_valid = 1'b0;
        tick(); check_ifid("wrap", 12'd0, 1'b1, 19'd4095, 12'd0, 1'b0);

        // Reach pc=9 with a valid entry, then an async reset pulse mid-cycle
        redirect_valid = 1'b1; redirect_pc = 12'd8;
        tick();
        redirect_valid = 1'b0;
        tick(); check_ifid("at9", 12'd9, 1'b1, 19'd8, 12'd9, 1'b0);
        check_perf("before_rst", 16'd12, 16'd4, 16'd5);
        #2;
        rst = 1'b1;
        #1;
        check_ifid("async_rst", 12'd0, 1'b0, 19'd0, 12'd0, 1'b0);
        check_perf("async_rst", 16'd0, 16'd0, 16'd0);
        rst = 1'b0;
        check_eq("rst_release.addr", 32'(imem_addr), 32'd0);
        tick(); check_ifid("restart", 12'd1, 1'b1, 19'd0, 12'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
